crc8_pkt_sender: RTL and testbench
==================================

Name: crc8_pkt_sender

Overview:
Upstream feeder for the CRC8816 byte-serial CRC checker. It accepts one packet per handshake: a DATA_LENGTH-bit payload word plus its received 8-bit CRC. It streams the packet into the checker as contiguous bytes, MSB first, with the CRC byte last. It then waits for the checker's done/match verdict, or a timeout, and reports one status pulse per packet.

Parameters:
DATA_LENGTH, 32, payload width in bits; must be a multiple of 8 and at least 8.
DATA_LENGTH_BYTES, DATA_LENGTH/8, number of payload bytes per packet.
TIMEOUT_CYCLES, 16, maximum cycles to wait for i_done after the last byte; must be at least 2.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous, active-low reset.
i_valid  input  1  packet request from the producer.
o_ready  output  1  block can accept a packet (IDLE only).
i_data  input  DATA_LENGTH  payload word; byte [DATA_LENGTH-1 -: 8] is sent first.
i_crc  input  8  received CRC byte, appended after the payload.
o_valid  output  1  byte strobe to CRC8816 i_valid.
o_last  output  1  final-byte flag to CRC8816 i_last.
o_data  output  8  byte to CRC8816 i_data.
i_done  input  1  from CRC8816 o_done.
i_match  input  1  from CRC8816 o_match; meaningful only while i_done=1.
o_status_valid  output  1  one-cycle pulse: packet verdict available.
o_status_ok  output  1  1 = CRC matched; qualified by o_status_valid.
o_timeout  output  1  one-cycle pulse with o_status_valid when no i_done arrived in time.

Behaviour:
- All outputs are registered.
- While reset=0: state=IDLE and every output is 0, including o_ready.
  - o_ready rises on the first clk edge after reset is released.
- Reset mid-packet: the packet is abandoned immediately; no status pulse is generated for it.
- States: IDLE, SEND, WAIT_DONE.
- IDLE:
  - o_ready=1.
  - Accept at edge T when i_valid & o_ready: latch i_data and i_crc, clear byte index, go to SEND.
  - o_ready=0 from T+1.
  - i_valid is ignored when o_ready=0; no queuing.
- SEND:
  - o_valid=1 for exactly DATA_LENGTH_BYTES+1 consecutive cycles, starting in cycle T+1.
  - Payload byte k (k=0..DATA_LENGTH_BYTES-1) is latched_word[DATA_LENGTH-1-8k -: 8].
  - The final cycle carries the latched CRC with o_last=1.
  - o_last=0 on all other cycles; no gaps and no downstream back-pressure.
  - i_done/i_match are ignored in SEND.
  - After the CRC byte, go to WAIT_DONE; o_valid, o_last and o_data all go to 0.
- WAIT_DONE:
  - The wait counter starts at 0 in the first WAIT_DONE cycle and increments each cycle.
  - Sampling i_done=1 at an edge gives o_status_valid=1 and o_status_ok=i_match for one cycle, then IDLE.
  - The counter reaching TIMEOUT_CYCLES-1 with i_done=0 gives o_status_valid=1, o_status_ok=0 and o_timeout=1 for one cycle, then IDLE.
  - i_done on the same edge as the final count takes priority: normal verdict, no timeout.
- o_ready re-asserts in the same cycle as the status pulse, so back-to-back packets are possible.
  - Minimum packet period: DATA_LENGTH_BYTES+3 cycles.
- Byte index width is clog2(DATA_LENGTH_BYTES+1); the wait counter width is clog2(TIMEOUT_CYCLES). Neither counter wraps: both clear on state exit.
- o_data holds 0 whenever o_valid=0.

Test Plan:
- Nominal: i_data=0x12345678, i_crc=0xAB accepted at T; i_done=1 with i_match=1 sampled 3 cycles after last byte.
  -> o_data 12,34,56,78,AB in T+1..T+5; o_last only at T+5; one o_status_valid pulse with ok=1, timeout=0.
- Mismatch: same packet, i_done=1 with i_match=0.
  -> o_status_ok=0, o_timeout=0, single pulse.
- Timeout: no i_done after last byte.
  -> o_status_valid=1, o_timeout=1, ok=0 in the 16th WAIT_DONE cycle; o_ready=1 in that same cycle.
- Busy: hold i_valid=1 with a new word 0xDEADBEEF during SEND, plus spurious i_done=1 in SEND.
  -> second word not accepted until o_ready returns; spurious done produces no status; then DE,AD,BE,EF,crc sent.
- Reset mid-SEND: assert reset=0 after 2 bytes.
  -> all outputs 0 asynchronously; after release o_ready=1 next edge; no status pulse; next packet streams cleanly from byte 0.
- Back-to-back: i_valid held high with i_done returned in the first WAIT_DONE cycle.
  -> packets start every DATA_LENGTH_BYTES+3 = 7 cycles.

Source files
------------

// File: rtl/crc8_pkt_sender.sv
// crc8_pkt_sender
//   Feeds one packet at a time into a byte-serial CRC8816 checker.
//   A packet is a DATA_LENGTH-bit payload word plus its received CRC byte.
//   The payload is streamed MSB byte first, followed by the CRC byte, which is
//   flagged with o_last. The block then waits for the checker's verdict, or a
//   timeout, and reports one status pulse per packet.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-low reset
//   i_valid        in   packet request from producer
//   o_ready        out  block can accept a packet (IDLE only)
//   i_data         in   payload word, top byte sent first
//   i_crc          in   received CRC byte, sent after the payload
//   o_valid        out  byte strobe to checker
//   o_last         out  final-byte flag to checker
//   o_data         out  byte to checker, 0 when o_valid=0
//   i_done         in   checker verdict strobe
//   i_match        in   checker verdict, meaningful with i_done
//   o_status_valid out  one-cycle verdict pulse
//   o_status_ok    out  1 = CRC matched, qualified by o_status_valid
//   o_timeout      out  one-cycle pulse with o_status_valid on timeout
module crc8_pkt_sender #(
  parameter int DATA_LENGTH       = 32,
  parameter int DATA_LENGTH_BYTES = DATA_LENGTH / 8,
  parameter int TIMEOUT_CYCLES    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [DATA_LENGTH-1:0] i_data,
  input  logic [7:0]             i_crc,
  output logic                   o_valid,
  output logic                   o_last,
  output logic [7:0]             o_data,
  input  logic                   i_done,
  input  logic                   i_match,
  output logic                   o_status_valid,
  output logic                   o_status_ok,
  output logic                   o_timeout
);

  localparam int IDX_W = $clog2(DATA_LENGTH_BYTES + 1);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  // byte_idx holds the index of the byte currently on o_data.
  localparam logic [IDX_W-1:0] LAST_PAYLOAD = IDX_W'(DATA_LENGTH_BYTES - 1);
  localparam logic [IDX_W-1:0] CRC_IDX      = IDX_W'(DATA_LENGTH_BYTES);
  // The timeout decision is taken one edge before the counter would read
  // TIMEOUT_CYCLES-1, so that the registered pulse lands in the final
  // wait cycle rather than one cycle later.
  localparam logic [CNT_W-1:0] LAST_WAIT    = CNT_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       byte_idx;
  logic [CNT_W-1:0]       wait_cnt;
  logic [DATA_LENGTH-1:0] shift_word;   // payload bytes not yet presented, top-aligned
  logic [7:0]             crc_byte;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      byte_idx       <= '0;
      wait_cnt       <= '0;
      shift_word     <= '0;
      crc_byte       <= '0;
      o_ready        <= 1'b0;
      o_valid        <= 1'b0;
      o_last         <= 1'b0;
      o_data         <= 8'h00;
      o_status_valid <= 1'b0;
      o_status_ok    <= 1'b0;
      o_timeout      <= 1'b0;
    end else begin
      // Status outputs are single-cycle pulses.
      o_status_valid <= 1'b0;
      o_status_ok    <= 1'b0;
      o_timeout      <= 1'b0;

      case (state)
        IDLE: begin
          o_ready <= 1'b1;
          if (i_valid && o_ready) begin
            // First byte goes out straight away; the rest are kept
            // top-aligned so each later byte is just the top slice.
            o_ready    <= 1'b0;
            o_valid    <= 1'b1;
            o_last     <= 1'b0;
            o_data     <= i_data[DATA_LENGTH-1 -: 8];
            shift_word <= i_data << 8;
            crc_byte   <= i_crc;
            byte_idx   <= '0;
            state      <= SEND;
          end
        end

        SEND: begin
          if (byte_idx == LAST_PAYLOAD) begin
            o_data   <= crc_byte;
            o_last   <= 1'b1;
            byte_idx <= byte_idx + IDX_W'(1);
          end else if (byte_idx == CRC_IDX) begin
            o_valid  <= 1'b0;
            o_last   <= 1'b0;
            o_data   <= 8'h00;
            byte_idx <= '0;
            wait_cnt <= '0;
            state    <= WAIT_DONE;
          end else begin
            o_data     <= shift_word[DATA_LENGTH-1 -: 8];
            shift_word <= shift_word << 8;
            byte_idx   <= byte_idx + IDX_W'(1);
          end
        end

        WAIT_DONE: begin
          if (i_done) begin
            // A verdict on the final count edge wins over the timeout.
            o_status_valid <= 1'b1;
            o_status_ok    <= i_match;
            o_ready        <= 1'b1;
            wait_cnt       <= '0;
            state          <= IDLE;
          end else if (wait_cnt == LAST_WAIT) begin
            o_status_valid <= 1'b1;
            o_timeout      <= 1'b1;
            o_ready        <= 1'b1;
            wait_cnt       <= '0;
            state          <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        default: begin
          state   <= IDLE;
          o_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc8_pkt_sender.sv
// tb_crc8_pkt_sender
//   Directed and randomized packets against a reference model that derives
//   the expected byte stream and verdict timing from packet-level rules.
module tb_crc8_pkt_sender;

  localparam int DL = 32;
  localparam int NB = DL / 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_valid;
  logic          o_ready;
  logic [DL-1:0] i_data;
  logic [7:0]    i_crc;
  logic          o_valid;
  logic          o_last;
  logic [7:0]    o_data;
  logic          i_done;
  logic          i_match;
  logic          o_status_valid;
  logic          o_status_ok;
  logic          o_timeout;

  crc8_pkt_sender #(
    .DATA_LENGTH(DL),
    .DATA_LENGTH_BYTES(NB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data(i_data),
    .i_crc(i_crc),
    .o_valid(o_valid),
    .o_last(o_last),
    .o_data(o_data),
    .i_done(i_done),
    .i_match(i_match),
    .o_status_valid(o_status_valid),
    .o_status_ok(o_status_ok),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int prev_pulse = 0;
  bit chained = 1'b0;
  int last_accept = 0;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(o_ready), 32'd0);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_last"}, 32'(o_last), 32'd0);
    check({tag, "_data"}, 32'(o_data), 32'd0);
    check({tag, "_sv"}, 32'(o_status_valid), 32'd0);
    check({tag, "_ok"}, 32'(o_status_ok), 32'd0);
    check({tag, "_to"}, 32'(o_timeout), 32'd0);
  endtask

  // done_at: wait cycle (1-based, counted after the CRC byte) in which i_done
  // is driven high; 0 means never. busy holds i_valid high with the next
  // packet during the whole transfer and raises a spurious i_done in SEND.
  task automatic send_packet(input logic [31:0] data, input logic [7:0] crc,
                             input int done_at, input bit match, input bit busy,
                             input logic [31:0] nxt_data, input logic [7:0] nxt_crc);
    logic [7:0] exp_bytes[$];
    int pulse_j;
    int n;
    bit ok_exp;
    bit to_exp;
    for (int k = 0; k < NB; k++)
      exp_bytes.push_back(8'((data >> (8 * (NB - 1 - k))) & 32'hFF));
    exp_bytes.push_back(crc);
    if (done_at >= 1 && done_at <= TO - 1) begin
      pulse_j = done_at + 1; ok_exp = match; to_exp = 1'b0;
    end else begin
      pulse_j = TO; ok_exp = 1'b0; to_exp = 1'b1;
    end

    n = 0;
    while (o_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(o_ready), 32'd1);
    if (chained) check("pkt_gap", 32'(cyc - last_accept), 32'(NB + 1 + prev_pulse));
    last_accept = cyc;
    i_valid = 1'b1; i_data = data; i_crc = crc; i_done = 1'b0; i_match = 1'b0;
    @(negedge clk);
    if (busy) begin
      i_data = nxt_data; i_crc = nxt_crc; i_done = 1'b1; i_match = 1'b1;
    end else begin
      i_valid = 1'b0;
    end

    for (int k = 0; k <= NB; k++) begin
      check("send_valid", 32'(o_valid), 32'd1);
      check("send_data", 32'(o_data), 32'(exp_bytes[k]));
      check("send_last", 32'(o_last), 32'(k == NB));
      check("send_ready", 32'(o_ready), 32'd0);
      check("send_sv", 32'(o_status_valid), 32'd0);
      @(negedge clk);
    end

    for (int j = 1; j <= pulse_j; j++) begin
      check("wait_valid", 32'(o_valid), 32'd0);
      check("wait_data", 32'(o_data), 32'd0);
      check("wait_last", 32'(o_last), 32'd0);
      if (j < pulse_j) begin
        check("wait_sv", 32'(o_status_valid), 32'd0);
        check("wait_ready", 32'(o_ready), 32'd0);
        check("wait_to", 32'(o_timeout), 32'd0);
      end else begin
        check("stat_sv", 32'(o_status_valid), 32'd1);
        check("stat_ok", 32'(o_status_ok), 32'(ok_exp));
        check("stat_to", 32'(o_timeout), 32'(to_exp));
        check("stat_ready", 32'(o_ready), 32'd1);
      end
      i_done = (j == done_at);
      i_match = match;
      if (j < pulse_j) @(negedge clk);
    end
    $display("pkt data=%08h crc=%02h done_at=%0d match=%0d busy=%0d -> ok=%0d timeout=%0d at wait cycle %0d",
             data, crc, done_at, match, busy, ok_exp, to_exp, pulse_j);
    prev_pulse = pulse_j;
    chained = 1'b1;
  endtask

  task automatic reset_mid_send(input logic [31:0] data, input logic [7:0] crc);
    int n;
    n = 0;
    while (o_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_ready_wait", 32'(o_ready), 32'd1);
    i_valid = 1'b1; i_data = data; i_crc = crc; i_done = 1'b0;
    @(negedge clk);
    i_valid = 1'b0;
    check("rst_b0", 32'(o_data), 32'(data[31:24]));
    @(negedge clk);
    check("rst_b1", 32'(o_data), 32'(data[23:16]));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("rst_async");
    @(negedge clk);
    check_all_zero("rst_hold");
    reset = 1'b1;
    @(negedge clk);
    check("rst_rel_ready", 32'(o_ready), 32'd1);
    check("rst_rel_valid", 32'(o_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      check("rst_no_status", 32'(o_status_valid), 32'd0);
      check("rst_no_valid", 32'(o_valid), 32'd0);
      @(negedge clk);
    end
    $display("reset mid-send data=%08h: packet abandoned", data);
    chained = 1'b0;
  endtask

  initial begin
    logic [31:0] cur_data;
    logic [31:0] nxt_data;
    logic [7:0]  cur_crc;
    logic [7:0]  nxt_crc;
    int          d;
    bit          m;
    bit          b;

    reset = 1'b0; i_valid = 1'b0; i_data = '0; i_crc = '0; i_done = 1'b0; i_match = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset_hold");
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_ready", 32'(o_ready), 32'd1);
    check("post_reset_valid", 32'(o_valid), 32'd0);
    $display("reset released: ready=%0d", o_ready);

    // Nominal, mismatch, timeout
    send_packet(32'h12345678, 8'hAB, 3, 1'b1, 1'b0, 32'h0, 8'h0);
    send_packet(32'h12345678, 8'hAB, 3, 1'b0, 1'b0, 32'h0, 8'h0);
    send_packet(32'h12345678, 8'hAB, 0, 1'b0, 1'b0, 32'h0, 8'h0);

    // Busy producer with spurious done, then back-to-back
    send_packet(32'h01020304, 8'h5A, 2, 1'b1, 1'b1, 32'hDEADBEEF, 8'hC3);
    send_packet(32'hDEADBEEF, 8'hC3, 1, 1'b1, 1'b1, 32'hCAFEF00D, 8'h3C);
    send_packet(32'hCAFEF00D, 8'h3C, 1, 1'b0, 1'b0, 32'h0, 8'h0);

    // Verdict on the final count edge, and one cycle too late
    send_packet(32'h00FF00FF, 8'h11, TO - 1, 1'b1, 1'b0, 32'h0, 8'h0);
    send_packet(32'hFF00FF00, 8'h22, TO, 1'b1, 1'b0, 32'h0, 8'h0);

    // Reset in the middle of SEND, then a clean packet
    reset_mid_send(32'hA1B2C3D4, 8'h77);
    send_packet(32'h55AA33CC, 8'h99, 2, 1'b1, 1'b0, 32'h0, 8'h0);

    // Randomized packets
    cur_data = $urandom;
    cur_crc  = 8'($urandom_range(0, 255));
    for (int i = 0; i < 20; i++) begin
      nxt_data = $urandom;
      nxt_crc  = 8'($urandom_range(0, 255));
      d = $urandom_range(0, TO + 1);
      m = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      send_packet(cur_data, cur_crc, d, m, b, nxt_data, nxt_crc);
      cur_data = nxt_data;
      cur_crc  = nxt_crc;
    end

    i_valid = 1'b0;
    i_done  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
